// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multi-cycle MIPS sequencing controller:
//   - state_e      : FSM state encoding (also exported on state_o for debug)
//   - OP_*         : opcodes of the supported instructions
//   - ALUOP_*      : ALU operation select codes
//   - ALUB_*       : ALU B-input mux select codes
//   - PCSRC_*      : PC source mux select codes
//   - op_supported : true for opcodes the controller knows how to sequence
// Optional feature macro used elsewhere in the slice: MULTICYCLE_MEM_WAIT_EN
// ---------------------------------------------------------------------------
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundle of signals between the sequencing controller and the datapath.
//   datapath -> controller : start_i, Op_i[5:0], Zero_i, mem_ready_i (*)
//   controller -> datapath : pc_en_o, IorD_o, MemRead_o, MemWrite_o,
//                            IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o,
//                            ALUSrcA_o, ALUSrcB_o[1:0], ALUOp_o[1:0],
//                            PCSource_o[1:0], illegal_o, state_o[3:0]
//   (*) mem_ready_i exists only when MULTICYCLE_MEM_WAIT_EN is defined.
// Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface multicycle_control_if;

    logic       start_i;
    logic [5:0] Op_i;
    logic       Zero_i;
`ifdef MULTICYCLE_MEM_WAIT_EN
    logic       mem_ready_i;
`endif

    logic       pc_en_o;
    logic       IorD_o;
    logic       MemRead_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic       RegDst_o;
    logic       MemtoReg_o;
    logic       RegWrite_o;
    logic       ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [1:0] ALUOp_o;
    logic [1:0] PCSource_o;
    logic       illegal_o;
    logic [3:0] state_o;

    modport master (
        input  
`ifdef MULTICYCLE_MEM_WAIT_EN
               mem_ready_i,
`endif
               start_i, Op_i, Zero_i,
        output pc_en_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o,
               MemtoReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
               PCSource_o, illegal_o, state_o
    );

    modport slave (
        output 
`ifdef MULTICYCLE_MEM_WAIT_EN
               mem_ready_i,
`endif
               start_i, Op_i, Zero_i,
        input  pc_en_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o,
               MemtoReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
               PCSource_o, illegal_o, state_o
    );

endinterface

// File: rtl/multicycle_control_out_decode.sv
// ---------------------------------------------------------------------------
// multicycle_out_decode
// Purely combinational Moore output map: current state -> control strobes.
// Only pc_en_o in BRANCH depends on an input (zero_i); with
// MULTICYCLE_MEM_WAIT_EN defined, IRWrite_o/pc_en_o in FETCH are also gated
// by mem_ready_i so the PC and IR only update once the fetch completes.
// Ports:
//   state_i     in  state_e  current FSM state
//   mem_ready_i in  1        memory done (only with MULTICYCLE_MEM_WAIT_EN)
//   zero_i      in  1        ALU zero flag
//   *_o         out          control strobes, see multicycle_control_if
// ---------------------------------------------------------------------------
module multicycle_out_decode
    import multicycle_pkg::*;
(
    input  state_e     state_i,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic       mem_ready_i,
`endif
    input  logic       zero_i,
    output logic       pc_en_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic [1:0] PCSource_o
);

    logic mem_rdy;
`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_rdy = mem_ready_i;
`else
    assign mem_rdy = 1'b1;
`endif

    always_comb begin
        pc_en_o    = 1'b0;
        IorD_o     = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        IRWrite_o  = 1'b0;
        RegDst_o   = 1'b0;
        MemtoReg_o = 1'b0;
        RegWrite_o = 1'b0;
        ALUSrcA_o  = 1'b0;
        ALUSrcB_o  = ALUB_REG;
        ALUOp_o    = ALUOP_ADD;
        PCSource_o = PCSRC_ALU;
        case (state_i)
            S_FETCH: begin
                // The read strobe stays up for the whole wait; the loads
                // only fire in the cycle the instruction word is valid.
                MemRead_o = 1'b1;
                IRWrite_o = mem_rdy;
                ALUSrcB_o = ALUB_FOUR;
                pc_en_o   = mem_rdy;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                ALUSrcB_o = ALUB_IMM_SH2;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = ALUB_IMM;
            end
            S_MEMRD: begin
                IorD_o    = 1'b1;
                MemRead_o = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg_o = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_MEMWR: begin
                IorD_o     = 1'b1;
                MemWrite_o = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o  = 1'b1;
                ALUOp_o    = ALUOP_SUB;
                PCSource_o = PCSRC_ALUOUT;
                pc_en_o    = zero_i;
            end
            S_JUMP: begin
                PCSource_o = PCSRC_JUMP;
                pc_en_o    = 1'b1;
            end
            default: ;  // IDLE and unused encodings drive nothing
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore sequencing FSM for a multi-cycle MIPS core sharing one ALU and one
// unified memory. Holds the state register and next-state logic; the
// per-state strobes come from multicycle_out_decode.
// Ports:
//   clk_i  in   clock, all state changes on the rising edge
//   rst_i  in   synchronous active-high reset, returns to IDLE
//   bus    master modport of multicycle_control_if (start/opcode/zero in,
//          control strobes, illegal_o and state_o out)
// Optional: MULTICYCLE_MEM_WAIT_EN adds mem_ready_i; FETCH, MEMRD and MEMWR
// then hold until memory reports completion.
// ---------------------------------------------------------------------------
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    multicycle_control_if.master  bus
);

    state_e state_q;
    state_e state_d;
    logic   mem_rdy;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_rdy = bus.mem_ready_i;
`else
    assign mem_rdy = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start_i) state_d = S_FETCH;
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op_i)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR, so anything but sw is a load.
            S_MEMADR: state_d = (bus.Op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;  // recover from unused encodings
        endcase
    end

    multicycle_out_decode u_out_decode (
        .state_i     (state_q),
`ifdef MULTICYCLE_MEM_WAIT_EN
        .mem_ready_i (bus.mem_ready_i),
`endif
        .zero_i      (bus.Zero_i),
        .pc_en_o     (bus.pc_en_o),
        .IorD_o      (bus.IorD_o),
        .MemRead_o   (bus.MemRead_o),
        .MemWrite_o  (bus.MemWrite_o),
        .IRWrite_o   (bus.IRWrite_o),
        .RegDst_o    (bus.RegDst_o),
        .MemtoReg_o  (bus.MemtoReg_o),
        .RegWrite_o  (bus.RegWrite_o),
        .ALUSrcA_o   (bus.ALUSrcA_o),
        .ALUSrcB_o   (bus.ALUSrcB_o),
        .ALUOp_o     (bus.ALUOp_o),
        .PCSource_o  (bus.PCSource_o)
    );

    assign bus.illegal_o = (state_q == S_DECODE) && !op_supported(bus.Op_i);
    assign bus.state_o   = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencing FSM that turns the CPU into a multi-cycle MIPS core sharing one ALU and one unified instruction/data memory. It issues per-cycle control strobes to the PC, instruction register, register file, memory and ALU muxes. It replaces the single-cycle `Control` decoder once the datapath is refactored to share resources. Supported opcodes are R-type, lw, sw, beq, j and addi.

## Interface
Parameters: none.

- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  leave IDLE when sampled high; ignored once running
- Op_i  in  6  opcode, instruction register bits [31:26]
- Zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory access complete; present only with MULTICYCLE_MEM_WAIT_EN
- pc_en_o  out  1  PC load enable
- IorD_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead_o / MemWrite_o  out  1 each  memory strobes
- IRWrite_o  out  1  instruction register load
- RegDst_o  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg_o  out  1  write data select: 0 = ALUOut, 1 = MDR
- RegWrite_o  out  1  register file write
- ALUSrcA_o  out  1  ALU A select: 0 = PC, 1 = A register
- ALUSrcB_o  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2
- ALUOp_o  out  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_o  out  1  unsupported opcode seen in DECODE
- state_o  out  4  current state encoding, for debug

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12. Encodings 13–15 return to FETCH.
- IDLE → FETCH when start_i=1. Every instruction begins in FETCH, which always goes to DECODE.
- DECODE transitions, by Op_i:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - anything else → FETCH, with illegal_o=1 during that DECODE cycle
- Remaining transitions:
  - MEMADR → MEMRD for lw, MEMWR for sw
  - MEMRD → MEMWB
  - EXEC → RWB
  - ADDIEX → ADDIWB
  - MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB → FETCH
- Outputs asserted per state; every output not listed is 0, and every output is 0 in IDLE:
  - FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, pc_en=1
  - DECODE: ALUSrcB=11
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10
  - MEMRD: IorD=1, MemRead=1
  - MEMWB: MemtoReg=1, RegWrite=1
  - MEMWR: IorD=1, MemWrite=1
  - EXEC: ALUSrcA=1, ALUOp=10
  - RWB: RegDst=1, RegWrite=1
  - ADDIWB: RegWrite=1
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, pc_en=Zero_i
  - JUMP: PCSource=10, pc_en=1
- All outputs are a function of state only, except pc_en_o in BRANCH (follows Zero_i) and illegal_o (follows Op_i).

## Timing
- Reset: state=IDLE, all outputs 0, state_o=0. Asserting rst_i mid-instruction aborts it; no write strobe is asserted in the cycle after reset.
- Latency in cycles, counted from FETCH entry back to the next FETCH entry:
  - beq: 3
  - j: 3
  - R-type: 4
  - sw: 4
  - addi: 4
  - lw: 5
  - illegal opcode: 2
- start_i is used only in IDLE. The controller never returns to IDLE except through rst_i.
- rst_i has priority over start_i when both are high in the same cycle.

## Configuration
- With MULTICYCLE_MEM_WAIT_EN defined:
  - The mem_ready_i port exists.
  - FETCH, MEMRD and MEMWR hold their state while mem_ready_i=0.
  - In FETCH, IRWrite_o and pc_en_o are gated by mem_ready_i.
  - MemRead_o and MemWrite_o stay asserted throughout the wait.
  - Each wait cycle adds one cycle to the latencies above.
- Without the macro: no mem_ready_i port, and every memory state lasts exactly one cycle.

## Structure
- Package multicycle_pkg holds:
  - state encoding typedef
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp constants
  - ALUSrcB constants
  - PCSource constants
- One sub-module, multicycle_out_decode: pure combinational map from state (plus Zero_i, mem_ready_i) to the control outputs. The top module holds the state register and next-state logic.

## Test plan
- Reset and start: hold rst_i 2 cycles, then start_i=1 → state_o goes 0,1,2; all strobes 0 while in IDLE.
- lw (Op=100011) → states 1,2,3,4,5,1. MEMRD shows IorD=1 and MemRead=1; MEMWB shows RegWrite=1 and MemtoReg=1.
- beq (Op=000100):
  - Zero_i=1 → pc_en_o=1 with PCSource=01 in BRANCH.
  - Zero_i=0 → pc_en_o=0.
  - Both cases return to FETCH after 3 cycles.
- Illegal opcode (Op=111111) → illegal_o=1 for exactly one cycle, then back to FETCH; RegWrite_o and MemWrite_o never asserted.
- Reset mid-sw: assert rst_i in MEMADR → next state IDLE and MemWrite_o=0.
- MULTICYCLE_MEM_WAIT_EN, sw with mem_ready_i low 3 cycles in MEMWR → MemWrite_o high for 4 cycles, then FETCH.
